// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer between the IF/ID register and dual-issue decode.
// Up to two instructions enter per cycle and up to two leave, all in program order.
// no_new_fetch holds fetch early enough that an in-flight pair is never lost.
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     flush,
    input  logic                     push_valid1,
    input  logic                     push_valid2,
    input  logic [31:0]              push_instr1,
    input  logic [31:0]              push_instr2,
    input  logic [31:0]              push_addr,
    input  logic [1:0]               pop_count,
    output logic [31:0]              out_instr1,
    output logic [31:0]              out_addr1,
    output logic                     out_valid1,
    output logic [31:0]              out_instr2,
    output logic [31:0]              out_addr2,
    output logic                     out_valid2,
    output logic                     no_new_fetch,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic [31:0]   addr_q  [DEPTH];
    logic [31:0]   addr_d  [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic [CW-1:0] free_slots;
    logic [1:0]    pushed;
    logic          push_fits;
    logic          pop_bad;
    logic [CW-1:0] pop_eff;
    logic [PW-1:0] slot2_idx;
    logic [PW-1:0] head_nxt;

    assign free_slots = DEPTH_C - count_q;
    assign pushed     = {1'b0, push_valid1} + {1'b0, push_valid2};
    // capacity is judged on the start-of-cycle count; popped slots are not reusable yet
    assign push_fits  = CW'(pushed) <= free_slots;
    assign pop_bad    = (pop_count == 2'd3) || (CW'(pop_count) > count_q);
    assign slot2_idx  = push_valid1 ? wr_ptr_q + PW'(1) : wr_ptr_q;
    assign head_nxt   = rd_ptr_q + PW'(1);

    // effective pop: illegal code 3 pops nothing, otherwise clamp to occupancy
    always_comb begin
        pop_eff = CW'(pop_count);
        if (pop_count == 2'd3) begin
            pop_eff = '0;
        end else if (CW'(pop_count) > count_q) begin
            pop_eff = count_q;
        end
    end

    // next-state for storage, pointers, occupancy and sticky error flags
    always_comb begin
        instr_d     = instr_q;
        addr_d      = addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fits) begin
                if (push_valid1) begin
                    instr_d[wr_ptr_q] = push_instr1;
                    addr_d[wr_ptr_q]  = push_addr;
                end
                if (push_valid2) begin
                    instr_d[slot2_idx] = push_instr2;
                    addr_d[slot2_idx]  = push_addr + 32'h4;
                end
                wr_ptr_d = wr_ptr_q + PW'(pushed);
                count_d  = count_q + CW'(pushed) - pop_eff;
            end else begin
                overflow_d = 1'b1;
                count_d    = count_q - pop_eff;
            end
            rd_ptr_d = rd_ptr_q + PW'(pop_eff);
            if (pop_bad) begin
                underflow_d = 1'b1;
            end
        end
    end

    // state registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                addr_q[i]  <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign out_valid1    = count_q >= CW'(1);
    assign out_valid2    = count_q >= CW'(2);
    assign out_instr1    = out_valid1 ? instr_q[rd_ptr_q] : 32'h0;
    assign out_addr1     = out_valid1 ? addr_q[rd_ptr_q]  : 32'h0;
    assign out_instr2    = out_valid2 ? instr_q[head_nxt] : 32'h0;
    assign out_addr2     = out_valid2 ? addr_q[head_nxt]  : 32'h0;
    // room for the pair sitting in IF/ID plus the pair accepted during the hold cycle
    assign no_new_fetch  = free_slots < CW'(4);
    assign count         = count_q;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH = 8) with hand-computed expectations.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        flush;
    logic        push_valid1, push_valid2;
    logic [31:0] push_instr1, push_instr2, push_addr;
    logic [1:0]  pop_count;
    logic [31:0] out_instr1, out_addr1, out_instr2, out_addr2;
    logic        out_valid1, out_valid2, no_new_fetch;
    logic [3:0]  count;
    logic        overflow_err, underflow_err;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(.DEPTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .flush(flush),
        .push_valid1(push_valid1), .push_valid2(push_valid2),
        .push_instr1(push_instr1), .push_instr2(push_instr2), .push_addr(push_addr),
        .pop_count(pop_count),
        .out_instr1(out_instr1), .out_addr1(out_addr1), .out_valid1(out_valid1),
        .out_instr2(out_instr2), .out_addr2(out_addr2), .out_valid2(out_valid2),
        .no_new_fetch(no_new_fetch), .count(count),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush       = 1'b0;
        push_valid1 = 1'b0;
        push_valid2 = 1'b0;
        push_instr1 = '0;
        push_instr2 = '0;
        push_addr   = '0;
        pop_count   = 2'd0;
    endtask

    task automatic set_pair(input logic [31:0] a, input logic [31:0] i1, input logic [31:0] i2);
        push_valid1 = 1'b1;
        push_valid2 = 1'b1;
        push_addr   = a;
        push_instr1 = i1;
        push_instr2 = i2;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid1", 32'(out_valid1), 32'd0);
        chk("rst_nnf", 32'(no_new_fetch), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
        chk("rst_unf", 32'(underflow_err), 32'd0);
        RESET = 1'b1;

        // pair push
        set_pair(32'h100, 32'hAAAA0001, 32'hBBBB0002);
        tick();
        idle();
        chk("pair_instr1", out_instr1, 32'hAAAA0001);
        chk("pair_addr1", out_addr1, 32'h100);
        chk("pair_instr2", out_instr2, 32'hBBBB0002);
        chk("pair_addr2", out_addr2, 32'h104);
        chk("pair_count", 32'(count), 32'd2);
        pop_count = 2'd2;
        tick();
        idle();
        chk("pop2_count", 32'(count), 32'd0);
        chk("empty_instr1", out_instr1, 32'h0);

        // slot 2 only
        push_valid2 = 1'b1;
        push_addr   = 32'h200;
        push_instr2 = 32'hCCCC0003;
        tick();
        idle();
        chk("single_instr1", out_instr1, 32'hCCCC0003);
        chk("single_addr1", out_addr1, 32'h204);
        chk("single_valid2", 32'(out_valid2), 32'd0);
        chk("single_instr2", out_instr2, 32'h0);
        chk("single_count", 32'(count), 32'd1);
        pop_count = 2'd1;
        tick();
        idle();
        chk("single_drain", 32'(count), 32'd0);

        // fill to capacity, then overflow
        for (int p = 0; p < 5; p++) begin
            set_pair(32'h1000 + 32'(8 * p), 32'h11110000 + 32'(p), 32'h22220000 + 32'(p));
            tick();
            idle();
            if (p == 1) begin
                chk("fill4_count", 32'(count), 32'd4);
                chk("fill4_nnf", 32'(no_new_fetch), 32'd0);
            end
            if (p == 2) begin
                chk("fill6_count", 32'(count), 32'd6);
                chk("fill6_nnf", 32'(no_new_fetch), 32'd1);
            end
            if (p == 3) begin
                chk("fill8_count", 32'(count), 32'd8);
                chk("fill8_ovf", 32'(overflow_err), 32'd0);
            end
        end
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow_err), 32'd1);
        chk("ovf_head_instr", out_instr1, 32'h11110000);
        chk("ovf_head_addr2", out_addr2, 32'h1004);
        for (int j = 0; j < 4; j++) begin
            pop_count = 2'd2;
            tick();
            idle();
            if (j < 3) begin
                chk("drain_addr1", out_addr1, 32'h1000 + 32'(8 * (j + 1)));
                chk("drain_instr2", out_instr2, 32'h22220000 + 32'(j + 1));
            end
        end
        chk("drain_count", 32'(count), 32'd0);

        // steady 2-in/2-out across pointer wrap
        for (int p = 0; p < 2; p++) begin
            set_pair(32'h3000 + 32'(8 * p), 32'hC0DE0000 + 32'(2 * p), 32'hC0DE0000 + 32'(2 * p + 1));
            tick();
        end
        idle();
        chk("wrap_pre_count", 32'(count), 32'd4);
        for (int k = 0; k < 10; k++) begin
            set_pair(32'h3000 + 32'(8 * (k + 2)), 32'hC0DE0000 + 32'(2 * (k + 2)),
                     32'hC0DE0000 + 32'(2 * (k + 2) + 1));
            pop_count = 2'd2;
            tick();
            idle();
            chk("wrap_count", 32'(count), 32'd4);
            chk("wrap_addr1", out_addr1, 32'h3000 + 32'(8 * (k + 1)));
            chk("wrap_instr2", out_instr2, 32'hC0DE0000 + 32'(2 * k + 3));
        end

        // flush with simultaneous push and pop
        push_valid1 = 1'b1;
        push_addr   = 32'h5000;
        push_instr1 = 32'h55550000;
        tick();
        idle();
        chk("pre_flush_count", 32'(count), 32'd5);
        set_pair(32'h5100, 32'h55551111, 32'h55552222);
        pop_count = 2'd2;
        flush     = 1'b1;
        tick();
        idle();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid1", 32'(out_valid1), 32'd0);
        chk("flush_nnf", 32'(no_new_fetch), 32'd0);
        chk("flush_instr1", out_instr1, 32'h0);
        set_pair(32'h6000, 32'h66660000, 32'h66661111);
        tick();
        idle();
        chk("postflush_addr1", out_addr1, 32'h6000);
        chk("postflush_addr2", out_addr2, 32'h6004);
        chk("postflush_count", 32'(count), 32'd2);

        // underflow by over-pop
        chk("unf_clear", 32'(underflow_err), 32'd0);
        pop_count = 2'd1;
        tick();
        idle();
        chk("unf_pre_count", 32'(count), 32'd1);
        pop_count = 2'd2;
        tick();
        idle();
        chk("unf_count", 32'(count), 32'd0);
        chk("unf_flag", 32'(underflow_err), 32'd1);
        chk("ovf_sticky", 32'(overflow_err), 32'd1);

        // asynchronous reset mid-stream
        set_pair(32'h7000, 32'h77770000, 32'h77771111);
        tick();
        idle();
        chk("prerst_count", 32'(count), 32'd2);
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid1", 32'(out_valid1), 32'd0);
        chk("arst_instr1", out_instr1, 32'h0);
        chk("arst_addr2", out_addr2, 32'h0);
        chk("arst_ovf", 32'(overflow_err), 32'd0);
        chk("arst_unf", 32'(underflow_err), 32'd0);
        tick();
        RESET = 1'b1;

        // illegal pop code 3 pops nothing but flags underflow
        set_pair(32'h8000, 32'h88880000, 32'h88881111);
        tick();
        idle();
        pop_count = 2'd3;
        tick();
        idle();
        chk("pop3_count", 32'(count), 32'd2);
        chk("pop3_flag", 32'(underflow_err), 32'd1);
        chk("pop3_addr1", out_addr1, 32'h8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
